// File: rtl/minute_counter_pkg.sv
// Shared clock definitions: terminal counts, count width, default debounce
// length, and the digit-split / 7-segment helpers reused by the display stages.
package minute_counter_pkg;

  localparam int COUNT_W          = 6;
  localparam int MINUTE_MAX       = 59;
  localparam int HOUR_MAX         = 23;
  localparam int DEBOUNCE_DEFAULT = 1000000;

  function automatic logic [3:0] tens_digit(input logic [COUNT_W-1:0] v);
    if (v >= 6'd50) return 4'd5;
    if (v >= 6'd40) return 4'd4;
    if (v >= 6'd30) return 4'd3;
    if (v >= 6'd20) return 4'd2;
    if (v >= 6'd10) return 4'd1;
    return 4'd0;
  endfunction

  function automatic logic [3:0] units_digit(input logic [COUNT_W-1:0] v);
    return 4'(v - COUNT_W'(tens_digit(v)) * COUNT_W'(10));
  endfunction

  // Segment order {g,f,e,d,c,b,a}, active high; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d, input logic en);
    if (!en) return 7'h00;
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/minute_counter_debounce.sv
// button_debounce: the output level follows din only after din has differed
// from it for CYCLES consecutive clocks. Used when MINUTE_DEBOUNCE_EN is defined.
module button_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk50,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;

  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == LAST) dout_d = din;
      else               cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  // Button is active-low, so the filter powers up in the released state.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      dout_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/minute_counter.sv
// Minutes stage: counts 0..59 on seconds-carry ticks, manual up/down adjust,
// carry pulse to the hours stage. Define MINUTE_DEBOUNCE_EN to debounce control1.
module minute_counter
  import minute_counter_pkg::*;
#(
  parameter int MAX_COUNT       = MINUTE_MAX,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic               clk50,
  input  logic               reset,
  input  logic               sec_carry,
  input  logic               control0,
  input  logic               control1,
  input  logic               disable_minute,
  output logic [COUNT_W-1:0] count,
  output logic               equal60,
  output logic [6:0]         led2,
  output logic [6:0]         led1
);

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  logic sec_s1_q, sec_s1_d, sec_s2_q, sec_s2_d, sec_prev_q, sec_prev_d;
  logic ctl_s1_q, ctl_s1_d, ctl_s2_q, ctl_s2_d, ctl_prev_q, ctl_prev_d;
  logic ctl_level;
  logic tick, press;
  logic [COUNT_W-1:0] count_q, count_d, up_val, down_val;
  logic pending_q, pending_d, equal60_q, equal60_d;

`ifdef MINUTE_DEBOUNCE_EN
  button_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk50 (clk50),
    .reset (reset),
    .din   (ctl_s2_q),
    .dout  (ctl_level)
  );
`else
  assign ctl_level = ctl_s2_q;
`endif

  always_comb begin
    sec_s1_d   = sec_carry;
    sec_s2_d   = sec_s1_q;
    sec_prev_d = sec_s2_q;
    ctl_s1_d   = control1;
    ctl_s2_d   = ctl_s1_q;
    ctl_prev_d = ctl_level;

    tick  = sec_s2_q & ~sec_prev_q & ~disable_minute;
    press = ~ctl_level & ctl_prev_q;

    up_val   = (count_q >= MAX_C) ? '0 : count_q + COUNT_W'(1);
    down_val = (count_q == '0) ? MAX_C :
               (count_q > MAX_C) ? '0 : count_q - COUNT_W'(1);

    count_d   = count_q;
    pending_d = pending_q;
    equal60_d = 1'b0;
    // A press wins the cycle; a coincident tick waits one cycle in pending.
    if (press) begin
      count_d = control0 ? up_val : down_val;
      if (tick) pending_d = 1'b1;
    end else if (tick || pending_q) begin
      pending_d = 1'b0;
      count_d   = up_val;
      equal60_d = (count_q == MAX_C);
    end
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      sec_s1_q   <= 1'b0;
      sec_s2_q   <= 1'b0;
      sec_prev_q <= 1'b0;
      ctl_s1_q   <= 1'b1;
      ctl_s2_q   <= 1'b1;
      ctl_prev_q <= 1'b1;
      count_q    <= '0;
      pending_q  <= 1'b0;
      equal60_q  <= 1'b0;
    end else begin
      sec_s1_q   <= sec_s1_d;
      sec_s2_q   <= sec_s2_d;
      sec_prev_q <= sec_prev_d;
      ctl_s1_q   <= ctl_s1_d;
      ctl_s2_q   <= ctl_s2_d;
      ctl_prev_q <= ctl_prev_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      equal60_q  <= equal60_d;
    end
  end

  assign count   = count_q;
  assign equal60 = equal60_q;
  assign led2    = seg7(tens_digit(count_q), 1'b1);
  assign led1    = seg7(units_digit(count_q), 1'b1);

endmodule

// File: tb/tb_minute_counter.sv
// Scoreboard bench for minute_counter: a cycle-level reference model pushes
// expected outputs each clock; a monitor pops and compares on the falling edge.
module tb_minute_counter;

  localparam int DB = 4;

  logic       clk50 = 1'b0;
  logic       reset = 1'b0;
  logic       sec_carry = 1'b0;
  logic       control0 = 1'b1;
  logic       control1 = 1'b1;
  logic       disable_minute = 1'b0;
  logic [5:0] count;
  logic       equal60;
  logic [6:0] led2, led1;

  minute_counter #(.MAX_COUNT(59), .DEBOUNCE_CYCLES(DB)) dut (
    .clk50          (clk50),
    .reset          (reset),
    .sec_carry      (sec_carry),
    .control0       (control0),
    .control1       (control1),
    .disable_minute (disable_minute),
    .count          (count),
    .equal60        (equal60),
    .led2           (led2),
    .led1           (led1)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    int         cnt;
    bit         eq;
    logic [6:0] l2;
    logic [6:0] l1;
  } exp_t;

  exp_t       sb_q[$];
  logic [6:0] seg_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_checks = 0;
  int n_pass   = 0;
  int eq_seen  = 0;

  // Reference model: minute value and pending-tick flag, plus the raw input
  // history needed to reproduce the 2-stage synchronizer delay.
  int       m_count = 0;
  bit       m_pend  = 0;
  bit       m_eq    = 0;
  bit [2:0] sec_h   = 3'b000;
  bit [2:0] ctl_h   = 3'b111;
`ifdef MINUTE_DEBOUNCE_EN
  bit filt      = 1'b1;
  bit filt_prev = 1'b1;
  int run       = 0;
`endif

  function automatic exp_t model_out();
    exp_t e;
    e.cnt = m_count;
    e.eq  = m_eq;
    e.l2  = seg_tbl[m_count / 10];
    e.l1  = seg_tbl[m_count % 10];
    return e;
  endfunction

  function automatic void model_clear();
    m_count = 0;
    m_pend  = 0;
    m_eq    = 0;
    sec_h   = 3'b000;
    ctl_h   = 3'b111;
`ifdef MINUTE_DEBOUNCE_EN
    filt      = 1'b1;
    filt_prev = 1'b1;
    run       = 0;
`endif
  endfunction

  function automatic void model_step();
    bit tick, press, lvl, lvl_prev;
    tick = sec_h[1] && !sec_h[2] && !disable_minute;
`ifdef MINUTE_DEBOUNCE_EN
    lvl      = filt;
    lvl_prev = filt_prev;
`else
    lvl      = ctl_h[1];
    lvl_prev = ctl_h[2];
`endif
    press = !lvl && lvl_prev;
    m_eq  = 0;
    if (press) begin
      m_count = control0 ? (m_count + 1) % 60 : (m_count + 59) % 60;
      if (tick) m_pend = 1;
    end else if (tick || m_pend) begin
      m_eq    = (m_count == 59);
      m_count = (m_count + 1) % 60;
      m_pend  = 0;
    end
`ifdef MINUTE_DEBOUNCE_EN
    filt_prev = filt;
    if (ctl_h[1] != filt) begin
      run++;
      if (run == DB) begin
        filt = ctl_h[1];
        run  = 0;
      end
    end else begin
      run = 0;
    end
`endif
    sec_h = {sec_h[1:0], sec_carry};
    ctl_h = {ctl_h[1:0], control1};
  endfunction

  always @(posedge clk50) begin
    if (!reset) model_clear();
    else        model_step();
    sb_q.push_back(model_out());
  end

  // Reset clears outputs at once, so the entry awaiting comparison is replaced.
  always @(negedge reset) begin
    model_clear();
    if (sb_q.size() > 0) sb_q[sb_q.size() - 1] = model_out();
  end

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk50);
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("[TB] FAIL scoreboard: queue size 0, required at least 1");
      end else begin
        e = sb_q.pop_front();
        check("count", int'(count), e.cnt);
        check("equal60", int'(equal60), int'(e.eq));
        check("led2", int'(led2), int'(e.l2));
        check("led1", int'(led1), int'(e.l1));
      end
      if (equal60 === 1'b1) eq_seen++;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  task automatic sec_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      sec_carry = 1'b1;
      wait_cycles(3);
      sec_carry = 1'b0;
      wait_cycles(3);
    end
  endtask

  task automatic press_btn(input bit up);
    control0 = up;
    control1 = 1'b0;
    wait_cycles(8);
    control1 = 1'b1;
    wait_cycles(8);
  endtask

  initial begin : stimulus
    bit found;
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
    check("reset_count", int'(count), 0);
    check("reset_led2", int'(led2), int'(seg_tbl[0]));
    check("reset_led1", int'(led1), int'(seg_tbl[0]));
    eq_seen = 0;

    sec_pulses(59);
    wait_cycles(4);
    check("count_after_59", int'(count), 59);
    check("eq_before_wrap", eq_seen, 0);
    sec_carry = 1'b1;
    wait_cycles(2);
    check("wrap_before_3rd_edge", int'(count), 59);
    wait_cycles(1);
    check("wrap_at_3rd_edge", int'(count), 0);
    check("eq_at_3rd_edge", int'(equal60), 1);
    sec_carry = 1'b0;
    wait_cycles(4);
    check("eq_pulse_cycles", eq_seen, 1);

    press_btn(1'b0);
    check("down_wrap", int'(count), 59);
    press_btn(1'b1);
    check("up_wrap", int'(count), 0);
    check("eq_no_manual_carry", eq_seen, 1);

    press_btn(1'b0);
    press_btn(1'b0);
    check("count_58", int'(count), 58);
    control0  = 1'b1;
    control1  = 1'b0;
    sec_carry = 1'b1;
    wait_cycles(3);
    check("press_wins", int'(count), 59);
    wait_cycles(1);
    check("pending_wrap", int'(count), 0);
    check("pending_eq", int'(equal60), 1);
    control1  = 1'b1;
    sec_carry = 1'b0;
    wait_cycles(8);

    disable_minute = 1'b1;
    sec_pulses(2);
    press_btn(1'b1);
    sec_pulses(3);
    check("disabled_ticks", int'(count), 1);
    disable_minute = 1'b0;
    wait_cycles(2);

    control0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      control1 = ~control1;
      wait_cycles(2);
    end
    wait_cycles(8);
`ifdef MINUTE_DEBOUNCE_EN
    check("bounce", int'(count), 1);
`else
    check("bounce", int'(count), 5);
`endif
    control1 = 1'b0;
    wait_cycles(10);
    control1 = 1'b1;
    wait_cycles(10);
`ifdef MINUTE_DEBOUNCE_EN
    check("held_press", int'(count), 2);
`else
    check("held_press", int'(count), 6);
`endif

    repeat (300) begin
      sec_carry      = 1'($urandom_range(0, 1));
      control1       = 1'($urandom_range(0, 1));
      control0       = 1'($urandom_range(0, 1));
      disable_minute = ($urandom_range(0, 9) == 0);
      wait_cycles(int'($urandom_range(1, 4)));
    end
    control1       = 1'b1;
    sec_carry      = 1'b0;
    disable_minute = 1'b0;
    wait_cycles(10);

    #1 reset = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(2);
    press_btn(1'b0);
    check("pre_reset_59", int'(count), 59);
    sec_carry = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk50);
      #1;
      if (equal60 === 1'b1) found = 1'b1;
    end
    check("eq_before_reset", int'(found), 1);
    reset = 1'b0;
    #1;
    check("reset_mid_count", int'(count), 0);
    check("reset_mid_eq", int'(equal60), 0);
    check("reset_mid_led2", int'(led2), int'(seg_tbl[0]));
    check("reset_mid_led1", int'(led1), int'(seg_tbl[0]));
    sec_carry = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(6);
    check("post_reset_idle", int'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, required stimulus to finish");
    $fatal(1, "[TB] time limit");
  end

endmodule
